pll_lock_sequencer: RTL and testbench
=====================================

// Module: pll_lock_sequencer
// PURPOSE
//  Consumes the PLL's locked/RESETB pair and generates a clean system reset for the glitcher core.
//  - Synchronises the asynchronous lock flag and qualifies it for a stable window.
//  - Holds system reset for a fixed time after qualification.
//  - Pulses PLL reset if lock never arrives within a timeout.
//  - Re-asserts system reset on lock loss.
//  Clocked by the 12 MHz board reference clock, never by the PLL output.
// PARAMETERS
//  PLL_RST_CYCLES  4     cycles pll_resetb is held low per PLL reset pulse (>=1)
//  TIMEOUT_CYCLES  24000 max cycles waiting for lock before re-resetting PLL (2 ms @12 MHz, >=1)
//  STABLE_CYCLES   1200  consecutive synced-lock cycles required to qualify lock (>=1)
//  HOLD_CYCLES     16    extra cycles sys_reset stays high after qualification (>=1)
//  CNT_W           16    width of shared cycle counter; must hold max of the above
// PORTS
//  clock           in   1      12 MHz reference clock
//  reset           in   1      synchronous, active-high
//  pll_locked      in   1      PLL LOCK, asynchronous to clock
//  pll_resetb      out  1      to PLL RESETB, active-low
//  sys_reset       out  1      active-high reset to glitcher core
//  ready           out  1      high only in RUN
//  state_dbg       out  3      current FSM state encoding
//  loss_count      out  8      lock-loss events (only with PLL_SEQ_LOSS_COUNT_EN)
// BEHAVIOUR
//  - Sync: lock_s = pll_locked through 2 flops; sync flops reset to 0. The FSM uses lock_s only.
//  - Reset values: state=PLL_RST, cnt=0, pll_resetb=0, sys_reset=1, ready=0, loss_count=0.
//  - All outputs are registered and reflect the current state.
//  - States (encoding 0..4):
//    - PLL_RST: pll_resetb=0, sys_reset=1. After PLL_RST_CYCLES cycles -> WAIT_LOCK, cnt cleared.
//    - WAIT_LOCK: pll_resetb=1, sys_reset=1.
//      - lock_s=1 -> STABILIZE, cnt cleared.
//      - Else after TIMEOUT_CYCLES cycles -> PLL_RST.
//      - Lock has priority if both occur in the same cycle.
//    - STABILIZE: sys_reset=1.
//      - lock_s=0 on any cycle -> WAIT_LOCK; timeout cnt restarts at 0; loss not counted.
//      - STABLE_CYCLES consecutive cycles with lock_s=1 -> HOLD.
//    - HOLD: sys_reset=1.
//      - lock_s=0 -> WAIT_LOCK; loss not counted.
//      - After HOLD_CYCLES cycles -> RUN.
//    - RUN: sys_reset=0, ready=1.
//      - lock_s=0 -> WAIT_LOCK; sys_reset=1 and ready=0 from the next edge.
//  - Latency: pll_locked high and stable, first sampled at edge k -> sys_reset falls at edge
//    k+2+STABLE_CYCLES+HOLD_CYCLES.
//  - Lock loss in RUN: sys_reset rises 3 edges after pll_locked falls (2 sync + 1 FSM).
//  - Counter: single CNT_W counter, cleared on every state change, never wraps within a state.
//  - reset asserted mid-operation: next edge -> PLL_RST values above regardless of state.
//  - Glitches on pll_locked shorter than 1 cycle may be missed; this is harmless by design.
// CONFIGURATION
//  PLL_SEQ_LOSS_COUNT_EN defined:
//  - loss_count port exists. It increments by 1 on each RUN->WAIT_LOCK transition.
//  - Saturates at 255. Cleared only by reset.
//  PLL_SEQ_LOSS_COUNT_EN undefined:
//  - Port and counter are absent. All other behaviour is identical.
// TESTING  (PLL_RST_CYCLES=4, TIMEOUT_CYCLES=20, STABLE_CYCLES=8, HOLD_CYCLES=4)
//  1. Release reset, pll_locked high from edge 10 -> pll_resetb high at edge 4 after reset release;
//     sys_reset low and ready high at edge 24; state_dbg=4.
//  2. pll_locked held low -> pll_resetb low for 4 cycles every 24 cycles; sys_reset never falls.
//  3. In STABILIZE, drop pll_locked 1 cycle after 5 good cycles -> back to WAIT_LOCK;
//     full 8+4 qualification restarts; loss_count stays 0.
//  4. In RUN, drop pll_locked -> sys_reset=1 and ready=0 3 edges later; loss_count=1;
//     relock -> RUN again after 14 cycles.
//  5. 300 RUN lock losses -> loss_count stays at 255; assert reset -> loss_count=0,
//     state=PLL_RST next edge.
//  6. Assert reset during HOLD -> pll_resetb=0, sys_reset=1, ready=0 on next edge.
//     Build without PLL_SEQ_LOSS_COUNT_EN -> elaborates, scenarios 1-4 pass.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: qualifies PLL lock and sequences PLL RESETB and the system reset.
// Define PLL_SEQ_LOSS_COUNT_EN to add the saturating o_loss_count lock-loss counter.
module pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 24000,
  parameter int STABLE_CYCLES  = 1200,
  parameter int HOLD_CYCLES    = 16,
  parameter int CNT_W          = 16
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_pll_locked,
  output logic       o_pll_resetb,
  output logic       o_sys_reset,
  output logic       o_ready,
  output logic [2:0] o_state_dbg
`ifdef PLL_SEQ_LOSS_COUNT_EN
  ,
  output logic [7:0] o_loss_count
`endif
);
  localparam logic [2:0] S_PLL_RST = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_STAB    = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;
  localparam logic [CNT_W-1:0] L_RST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_STAB = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_HOLD = CNT_W'(HOLD_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pll_resetb;
  logic             r_sys_reset;
  logic             r_ready;
  logic             w_lock;
  logic             w_done;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] w_last;

  assign w_lock = r_sync[1];

  // RUN has no terminal count; the counter simply parks at its last value there.
  always_comb begin
    w_last = (r_state == S_PLL_RST) ? L_RST  :
             (r_state == S_WAIT)    ? L_WAIT :
             (r_state == S_STAB)    ? L_STAB : L_HOLD;
    w_done = (r_cnt == w_last);
    w_next = S_PLL_RST;
    case (r_state)
      S_PLL_RST: w_next = w_done ? S_WAIT : S_PLL_RST;
      S_WAIT:    w_next = w_lock ? S_STAB : (w_done ? S_PLL_RST : S_WAIT);
      S_STAB:    w_next = !w_lock ? S_WAIT : (w_done ? S_HOLD : S_STAB);
      S_HOLD:    w_next = !w_lock ? S_WAIT : (w_done ? S_RUN : S_HOLD);
      S_RUN:     w_next = w_lock ? S_RUN : S_WAIT;
      default:   w_next = S_PLL_RST;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync       <= 2'b00;
      r_state      <= S_PLL_RST;
      r_cnt        <= '0;
      r_pll_resetb <= 1'b0;
      r_sys_reset  <= 1'b1;
      r_ready      <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], i_pll_locked};
      r_state      <= w_next;
      r_cnt        <= (w_next != r_state) ? '0 : (w_done ? r_cnt : r_cnt + 1'b1);
      r_pll_resetb <= (w_next != S_PLL_RST);
      r_sys_reset  <= (w_next != S_RUN);
      r_ready      <= (w_next == S_RUN);
    end
  end

`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [7:0] r_loss_count;
  always_ff @(posedge i_clock) begin
    if (i_reset)
      r_loss_count <= 8'd0;
    else if (r_state == S_RUN && !w_lock && r_loss_count != 8'hFF)
      r_loss_count <= r_loss_count + 8'd1;
  end
  assign o_loss_count = r_loss_count;
`endif

  assign o_pll_resetb = r_pll_resetb;
  assign o_sys_reset  = r_sys_reset;
  assign o_ready      = r_ready;
  assign o_state_dbg  = r_state;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed scenarios plus random lock traffic against a phase/age reference model.
module tb_pll_lock_sequencer;
  localparam int PR = 4, TO = 20, ST = 8, HD = 4;
  logic clk = 1'b0, rst = 1'b1, lk = 1'b0;
  logic pll_resetb, sys_reset, ready;
  logic [2:0] state;
`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [7:0] loss;
`endif
  int n_checks = 0, n_fail = 0, edge_n = 0;
  int m_phase = 0, m_age = 0, m_loss = 0;
  bit m_smp[$];

  always #5 clk = ~clk;

  pll_lock_sequencer #(.PLL_RST_CYCLES(PR), .TIMEOUT_CYCLES(TO), .STABLE_CYCLES(ST),
                       .HOLD_CYCLES(HD), .CNT_W(16)) dut (
    .i_clock(clk), .i_reset(rst), .i_pll_locked(lk),
    .o_pll_resetb(pll_resetb), .o_sys_reset(sys_reset), .o_ready(ready),
    .o_state_dbg(state)
`ifdef PLL_SEQ_LOSS_COUNT_EN
    , .o_loss_count(loss)
`endif
  );

  // Phases 0..4 = reset pulse, wait, stabilise, hold, run; age = edges spent in the phase.
  function automatic void model_step(input bit r, input bit l);
    bit ls;
    int np;
    if (r) begin
      m_phase = 0; m_age = 0; m_loss = 0; m_smp.delete();
      return;
    end
    ls = (m_smp.size() >= 2) ? m_smp[0] : 1'b0;
    m_smp.push_back(l);
    if (m_smp.size() > 2) void'(m_smp.pop_front());
    m_age++;
    np = m_phase;
    if (m_phase == 0 && m_age >= PR) np = 1;
    else if (m_phase == 1) np = ls ? 2 : (m_age >= TO ? 0 : 1);
    else if (m_phase == 2) np = !ls ? 1 : (m_age >= ST ? 3 : 2);
    else if (m_phase == 3) np = !ls ? 1 : (m_age >= HD ? 4 : 3);
    else if (m_phase == 4 && !ls) begin
      np = 1;
      if (m_loss < 255) m_loss++;
    end
    if (np != m_phase) begin
      m_phase = np; m_age = 0;
    end
  endfunction

  task automatic tick();
    model_step(rst, lk);
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic do_reset();
    rst = 1'b1; lk = 1'b0;
    tick(); tick();
    rst = 1'b0;
    edge_n = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; lk = 1'($urandom);
    tick(); tick();
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_checks++; if (pll_resetb !== 1'b0) begin n_fail++; $display("FAIL reset_pll_resetb got %b want 0", pll_resetb); end
    n_checks++; if (sys_reset !== 1'b1) begin n_fail++; $display("FAIL reset_sys_reset got %b want 1", sys_reset); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
`ifdef PLL_SEQ_LOSS_COUNT_EN
    n_checks++; if (loss !== 8'd0) begin n_fail++; $display("FAIL reset_loss got %0d want 0", loss); end
`endif
  endtask

  task automatic test_startup();
    int first_rb = -1, first_run = -1, errs = 0;
    do_reset();
    for (int i = 1; i <= 30; i++) begin
      lk = (i >= 10);
      tick();
      if (pll_resetb === 1'b1 && first_rb < 0) first_rb = edge_n;
      if (sys_reset === 1'b0 && first_run < 0) first_run = edge_n;
      if (state !== 3'(m_phase)) errs++;
    end
    n_checks++; if (first_rb != PR) begin n_fail++; $display("FAIL startup_resetb_edge got %0d want %0d", first_rb, PR); end
    n_checks++; if (first_run != 10 + 2 + ST + HD) begin n_fail++; $display("FAIL startup_run_edge got %0d want %0d", first_run, 10 + 2 + ST + HD); end
    n_checks++; if (state !== 3'd4 || ready !== 1'b1) begin n_fail++; $display("FAIL startup_run_state got %0d/%b want 4/1", state, ready); end
    n_checks++; if (errs != 0) begin n_fail++; $display("FAIL startup_model got %0d errs want 0", errs); end
  endtask

  task automatic test_timeout();
    int errs = 0, first = -1;
    do_reset();
    lk = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (pll_resetb !== ((edge_n % (PR + TO)) >= PR) || sys_reset !== 1'b1 || ready !== 1'b0) begin
        errs++;
        if (first < 0) first = edge_n;
      end
    end
    n_checks++; if (errs != 0) begin n_fail++; $display("FAIL timeout_pattern got %0d errs (first edge %0d) want 0", errs, first); end
  endtask

  task automatic test_stab_glitch();
    int d, fall = -1, n = 0, saw_wait = 0;
    do_reset();
    lk = 1'b1;
    while (m_phase != 2 && n < 60) begin tick(); n++; end
    n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL glitch_reach_stab got %0d want 2", state); end
    repeat (5) tick();
    lk = 1'b0;
    tick();
    d = edge_n;
    lk = 1'b1;
    for (int i = 0; i < 40 && fall < 0; i++) begin
      tick();
      if (state === 3'd1) saw_wait = 1;
      if (sys_reset === 1'b0) fall = edge_n;
    end
    n_checks++; if (saw_wait != 1) begin n_fail++; $display("FAIL glitch_back_to_wait got %0d want 1", saw_wait); end
    n_checks++; if (fall != d + 1 + 2 + ST + HD) begin n_fail++; $display("FAIL glitch_requalify_edge got %0d want %0d", fall, d + 1 + 2 + ST + HD); end
`ifdef PLL_SEQ_LOSS_COUNT_EN
    n_checks++; if (loss !== 8'd0) begin n_fail++; $display("FAIL glitch_loss got %0d want 0", loss); end
`endif
  endtask

  task automatic test_run_loss();
    int n = 0, r, fall = -1;
    do_reset();
    lk = 1'b1;
    while (state !== 3'd4 && n < 60) begin tick(); n++; end
    n_checks++; if (state !== 3'd4) begin n_fail++; $display("FAIL loss_reach_run got %0d want 4", state); end
    lk = 1'b0;
    tick();
    n_checks++; if (sys_reset !== 1'b0) begin n_fail++; $display("FAIL loss_edge1 sys_reset got %b want 0", sys_reset); end
    tick();
    n_checks++; if (sys_reset !== 1'b0) begin n_fail++; $display("FAIL loss_edge2 sys_reset got %b want 0", sys_reset); end
    tick();
    n_checks++; if (sys_reset !== 1'b1 || ready !== 1'b0 || state !== 3'd1) begin n_fail++; $display("FAIL loss_edge3 got %b/%b/%0d want 1/0/1", sys_reset, ready, state); end
`ifdef PLL_SEQ_LOSS_COUNT_EN
    n_checks++; if (loss !== 8'd1) begin n_fail++; $display("FAIL loss_count got %0d want 1", loss); end
`endif
    tick();
    lk = 1'b1;
    r = edge_n + 1;
    for (int i = 0; i < 40 && fall < 0; i++) begin
      tick();
      if (sys_reset === 1'b0) fall = edge_n;
    end
    n_checks++; if (fall != r + 2 + ST + HD) begin n_fail++; $display("FAIL loss_relock_edge got %0d want %0d", fall, r + 2 + ST + HD); end
  endtask

  task automatic test_saturation();
`ifdef PLL_SEQ_LOSS_COUNT_EN
    int n;
    int stuck = 0;
    do_reset();
    lk = 1'b1;
    for (int k = 0; k < 300 && stuck == 0; k++) begin
      n = 0;
      while (state !== 3'd4 && n < 40) begin tick(); n++; end
      if (state !== 3'd4) stuck = 1;
      lk = 1'b0; tick();
      lk = 1'b1; tick();
    end
    repeat (4) tick();
    n_checks++; if (stuck != 0) begin n_fail++; $display("FAIL sat_reach_run got stuck=%0d want 0", stuck); end
    n_checks++; if (loss !== 8'd255) begin n_fail++; $display("FAIL sat_loss got %0d want 255", loss); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (loss !== 8'd0 || state !== 3'd0) begin n_fail++; $display("FAIL sat_reset got %0d/%0d want 0/0", loss, state); end
`endif
  endtask

  task automatic test_reset_in_hold();
    int n = 0;
    do_reset();
    lk = 1'b1;
    while (state !== 3'd3 && n < 60) begin tick(); n++; end
    n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL hold_reach got %0d want 3", state); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (pll_resetb !== 1'b0 || sys_reset !== 1'b1 || ready !== 1'b0 || state !== 3'd0) begin
      n_fail++; $display("FAIL hold_reset got %b/%b/%b/%0d want 0/1/0/0", pll_resetb, sys_reset, ready, state);
    end
  endtask

  task automatic test_random();
    int seg = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (seg == 0) begin
        lk = ~lk;
        seg = lk ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 30));
      end
      seg--;
      rst = ($urandom_range(0, 499) == 0);
      tick();
      n_checks++; if (state !== 3'(m_phase)) begin n_fail++; $display("FAIL rand_state edge %0d got %0d want %0d", edge_n, state, m_phase); end
      n_checks++; if (pll_resetb !== (m_phase != 0)) begin n_fail++; $display("FAIL rand_pll_resetb edge %0d got %b want %b", edge_n, pll_resetb, m_phase != 0); end
      n_checks++; if (sys_reset !== (m_phase != 4) || ready !== (m_phase == 4)) begin n_fail++; $display("FAIL rand_sys edge %0d got %b/%b want %b/%b", edge_n, sys_reset, ready, m_phase != 4, m_phase == 4); end
`ifdef PLL_SEQ_LOSS_COUNT_EN
      n_checks++; if (loss !== 8'(m_loss)) begin n_fail++; $display("FAIL rand_loss edge %0d got %0d want %0d", edge_n, loss, m_loss); end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_timeout();
    test_stab_glitch();
    test_run_loss();
    test_saturation();
    test_reset_in_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
